// File: rtl/stripe_pattern_detector.sv
// -----------------------------------------------------------------------------
// stripe_pattern_detector
//   Streaming zebra-crossing detector. Each accepted pixel is binarised
//   against a per-frame threshold and forwarded downstream as all-ones (white)
//   or zero (black). White run lengths are measured per row. Runs of
//   MIN_RUN..MAX_RUN pixels count as stripes, and rows with at least
//   MIN_STRIPES stripes count as stripe rows. Frame statistics and the
//   crossing decision are reported once per frame.
//
// Optional build macro: PATTERN_SOF_EN
//   Adds the x_sof input. An accepted pixel with x_sof=1 restarts the frame
//   at (0,0), and the partial frame is dropped without a report.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   x_valid/x_ready     input pixel handshake (x_ready = !y_valid || y_ready)
//   x_data              input pixel
//   threshold           binarisation threshold, sampled on each frame's first pixel
//   x_sof               start-of-frame marker (PATTERN_SOF_EN builds only)
//   y_valid/y_ready     binarised pixel handshake, one register stage
//   y_data              binarised pixel, all-ones for white, else 0
//   detection_valid     one-cycle pulse when the frame results update
//   crossing_detected   held frame decision (stripe rows >= MIN_ROWS)
//   white_count         white pixels in the last frame
//   stripe_rows         stripe rows in the last frame
//   max_stripes         largest per-row stripe count in the last frame
// -----------------------------------------------------------------------------
module stripe_pattern_detector #(
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned W           = 8,
  parameter int unsigned MIN_RUN     = 8,
  parameter int unsigned MAX_RUN     = 128,
  parameter int unsigned MIN_STRIPES = 3,
  parameter int unsigned MIN_ROWS    = 20,
  localparam int unsigned WCW        = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
  localparam int unsigned SRW        = $clog2(IMG_HEIGHT+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [W-1:0]   x_data,
  input  logic [W-1:0]   threshold,
`ifdef PATTERN_SOF_EN
  input  logic           x_sof,
`endif
  output logic           y_valid,
  input  logic           y_ready,
  output logic [W-1:0]   y_data,
  output logic           detection_valid,
  output logic           crossing_detected,
  output logic [WCW-1:0] white_count,
  output logic [SRW-1:0] stripe_rows,
  output logic [7:0]     max_stripes
);

  localparam int unsigned CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned RLW = $clog2(MAX_RUN+2);

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_WIDTH-1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_HEIGHT-1);
  localparam logic [RLW-1:0] RUN_SAT  = RLW'(MAX_RUN+1);
  localparam logic [RLW-1:0] RUN_MIN  = RLW'(MIN_RUN);
  localparam logic [RLW-1:0] RUN_MAX  = RLW'(MAX_RUN);
  localparam logic [7:0]     STR_MIN  = 8'(MIN_STRIPES);
  localparam logic [7:0]     STR_SAT  = 8'hFF;
  localparam logic [SRW-1:0] ROWS_MIN = SRW'(MIN_ROWS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  // State and datapath registers
  logic [1:0]     r_state;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [RLW-1:0] r_run;
  logic [7:0]     r_row_str;
  logic [W-1:0]   r_thr;
  logic [WCW-1:0] r_white_acc;
  logic [SRW-1:0] r_srows_acc;
  logic [7:0]     r_max_acc;

  // Output registers
  logic           r_y_valid;
  logic [W-1:0]   r_y_data;
  logic           r_det_valid;
  logic           r_crossing;
  logic [WCW-1:0] r_white_cnt;
  logic [SRW-1:0] r_stripe_rows;
  logic [7:0]     r_max_stripes;

  // Combinational next values
  logic [1:0]     w_state_nxt;
  logic           w_acc;
  logic           w_sof;
  logic           w_first;
  logic           w_white;
  logic           w_row_end;
  logic           w_frame_end;
  logic           w_close;
  logic           w_stripe;
  logic [W-1:0]   w_thr;
  logic [CW-1:0]  w_col;
  logic [CW-1:0]  w_col_nxt;
  logic [RW-1:0]  w_row;
  logic [RW-1:0]  w_row_nxt;
  logic [RLW-1:0] w_run;
  logic [RLW-1:0] w_run_inc;
  logic [RLW-1:0] w_run_len;
  logic [RLW-1:0] w_run_nxt;
  logic [7:0]     w_row_str;
  logic [7:0]     w_row_str_upd;
  logic [7:0]     w_row_str_nxt;
  logic [WCW-1:0] w_white_acc;
  logic [WCW-1:0] w_white_nxt;
  logic [SRW-1:0] w_srows_acc;
  logic [SRW-1:0] w_srows_nxt;
  logic [7:0]     w_max_acc;
  logic [7:0]     w_max_nxt;

  assign x_ready           = !r_y_valid || y_ready;
  assign y_valid           = r_y_valid;
  assign y_data            = r_y_data;
  assign detection_valid   = r_det_valid;
  assign crossing_detected = r_crossing;
  assign white_count       = r_white_cnt;
  assign stripe_rows       = r_stripe_rows;
  assign max_stripes       = r_max_stripes;

  // Per-pixel datapath: position, binarisation, run and row bookkeeping
  always_comb begin
    w_sof = 1'b0;
`ifdef PATTERN_SOF_EN
    w_sof = x_sof;
`endif
    w_acc   = x_valid && x_ready;
    // A start-of-frame marker behaves as if the counters were already at (0,0)
    // with empty accumulators, so the partial frame simply vanishes.
    w_col       = w_sof ? '0 : r_col;
    w_row       = w_sof ? '0 : r_row;
    w_run       = w_sof ? '0 : r_run;
    w_row_str   = w_sof ? '0 : r_row_str;
    w_white_acc = w_sof ? '0 : r_white_acc;
    w_srows_acc = w_sof ? '0 : r_srows_acc;
    w_max_acc   = w_sof ? '0 : r_max_acc;

    w_first     = (w_col == '0) && (w_row == '0);
    // The first pixel of a frame is compared against the freshly sampled threshold
    w_thr       = w_first ? threshold : r_thr;
    w_white     = (x_data >= w_thr);
    w_row_end   = (w_col == COL_LAST);
    w_frame_end = w_row_end && (w_row == ROW_LAST);

    w_col_nxt = w_row_end ? '0 : w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_row_end) begin
      w_row_nxt = w_frame_end ? '0 : w_row + RW'(1);
    end

    // Saturating at MAX_RUN+1 keeps over-long runs out of the stripe window
    w_run_inc = (w_run == RUN_SAT) ? RUN_SAT : w_run + RLW'(1);
    // At row end a white pixel is part of the run being closed
    w_run_len = w_white ? w_run_inc : w_run;
    w_close   = (!w_white && (w_run != '0)) || w_row_end;
    w_stripe  = w_close && (w_run_len >= RUN_MIN) && (w_run_len <= RUN_MAX);
    w_run_nxt = w_close ? '0 : w_run_len;

    w_row_str_upd = w_row_str;
    if (w_stripe && (w_row_str != STR_SAT)) begin
      w_row_str_upd = w_row_str + 8'd1;
    end
    w_row_str_nxt = w_row_end ? '0 : w_row_str_upd;

    w_white_nxt = w_white_acc + WCW'(w_white);
    w_srows_nxt = w_srows_acc;
    w_max_nxt   = w_max_acc;
    if (w_row_end) begin
      if (w_row_str_upd >= STR_MIN) begin
        w_srows_nxt = w_srows_acc + SRW'(1);
      end
      if (w_row_str_upd > w_max_acc) begin
        w_max_nxt = w_row_str_upd;
      end
    end
  end

  // Frame FSM next state; a pixel taken during REPORT opens the next frame
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc && w_frame_end) begin
      w_state_nxt = S_REPORT;
    end else if (w_acc) begin
      w_state_nxt = S_ACTIVE;
    end else if (r_state == S_REPORT) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, accumulators and frame report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_run         <= '0;
      r_row_str     <= '0;
      r_thr         <= '0;
      r_white_acc   <= '0;
      r_srows_acc   <= '0;
      r_max_acc     <= '0;
      r_det_valid   <= 1'b0;
      r_crossing    <= 1'b0;
      r_white_cnt   <= '0;
      r_stripe_rows <= '0;
      r_max_stripes <= '0;
    end else begin
      r_det_valid <= 1'b0;
      if (w_acc) begin
        r_col     <= w_col_nxt;
        r_row     <= w_row_nxt;
        r_run     <= w_run_nxt;
        r_row_str <= w_row_str_nxt;
        if (w_first) begin
          r_thr <= threshold;
        end
        if (w_frame_end) begin
          // Report includes the final pixel; accumulators restart empty
          r_white_cnt   <= w_white_nxt;
          r_stripe_rows <= w_srows_nxt;
          r_max_stripes <= w_max_nxt;
          r_crossing    <= (w_srows_nxt >= ROWS_MIN);
          r_det_valid   <= 1'b1;
          r_white_acc   <= '0;
          r_srows_acc   <= '0;
          r_max_acc     <= '0;
        end else begin
          r_white_acc <= w_white_nxt;
          r_srows_acc <= w_srows_nxt;
          r_max_acc   <= w_max_nxt;
        end
      end
    end
  end

  // Binarised output stage; held stable while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
    end else if (x_ready) begin
      r_y_valid <= w_acc;
      if (w_acc) begin
        r_y_data <= {W{w_white}};
      end
    end
  end

endmodule
